buzzer_tone_gen: RTL and testbench



---
 rtl/buzzer_pkg.sv | 16 +
 rtl/buzzer_tone_div.sv | 55 +++++
 rtl/buzzer_tone_gen.sv | 189 ++++++++++++++++++
 tb/tb_buzzer_tone_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone generator.
//   state_e           : sequencer states (IDLE / TONE / GAP)
//   *_W_DEFAULT       : default widths for half-period, durations and beep counts
package buzzer_pkg;

  localparam int HP_W_DEFAULT  = 24;
  localparam int CNT_W_DEFAULT = 16;
  localparam int REP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage : buzzer_pkg

// File: rtl/buzzer_tone_div.sv
// Half-period cycle divider for the buzzer sequencer.
// Ports:
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   load_i         : restart the divider at the beginning of a high half
//   en_i           : count enable (sequence active)
//   half_period_i  : half-period in clock cycles (>= 2)
//   half_tick_o    : last cycle of a half-period (buzzer toggle point)
//   period_tick_o  : last cycle of a full period (end of the low half)
module buzzer_tone_div #(
  parameter int HP_W = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            half_tick_o,
  output logic            period_tick_o
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  // 0 = first (high) half of the period, 1 = second (low) half
  logic            phase_q, phase_d;

  assign half_tick_o   = en_i && (cnt_q == '0);
  assign period_tick_o = half_tick_o && phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = half_period_i - HP_W'(1);
      phase_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d   = half_period_i - HP_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule : buzzer_tone_div

// File: rtl/buzzer_tone_gen.sv
// Beep sequencer: latches the configuration on an accepted start and emits
// repeated tone bursts separated by silent gaps on buzzer_o.
// Ports:
//   ACLK, ARESETN  : clock, asynchronous active-low reset
//   start, stop    : one-cycle control strobes (stop has priority)
//   half_period    : tone half-period in cycles (>= 2)
//   on_periods     : tone periods per beep (>= 1)
//   off_periods    : silent periods between beeps (0 = back-to-back)
//   repeat_count   : beeps per sequence (0 = run until stop)
//   buzzer_o       : square-wave drive
//   busy           : sequence in progress
//   done           : one-cycle pulse when a sequence ends or is stopped
//   cfg_err        : one-cycle pulse when a start is rejected
//   beeps_done     : completed beeps of the current/last sequence (saturating)
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int HP_W  = HP_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int REP_W = REP_W_DEFAULT
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             start,
  input  logic             stop,
  input  logic [HP_W-1:0]  half_period,
  input  logic [CNT_W-1:0] on_periods,
  input  logic [CNT_W-1:0] off_periods,
  input  logic [REP_W-1:0] repeat_count,
  output logic             buzzer_o,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [REP_W-1:0] beeps_done
);

  state_e           state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [REP_W-1:0] beeps_q, beeps_d;
  logic             buzzer_q, buzzer_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_ok;
  logic             accept;
  logic [HP_W-1:0]  div_hp;
  logic             half_tick;
  logic             period_tick;
  logic [REP_W-1:0] beeps_inc;

  assign cfg_ok = (half_period >= HP_W'(2)) && (on_periods != '0);
  assign accept = (state_q == IDLE) && start && !stop && cfg_ok;
  // The divider loads from the live input on the accepting edge, and from
  // the latched copy on every reload afterwards.
  assign div_hp = (state_q == IDLE) ? half_period : hp_q;
  assign beeps_inc = (beeps_q == '1) ? beeps_q : beeps_q + REP_W'(1);

  buzzer_tone_div #(
    .HP_W(HP_W)
  ) u_div (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .load_i       (accept),
    .en_i         (state_q != IDLE),
    .half_period_i(div_hp),
    .half_tick_o  (half_tick),
    .period_tick_o(period_tick)
  );

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    on_d      = on_q;
    off_d     = off_q;
    rep_d     = rep_q;
    per_cnt_d = per_cnt_q;
    beeps_d   = beeps_q;
    buzzer_d  = buzzer_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        buzzer_d = 1'b0;
        if (start && !stop) begin
          if (cfg_ok) begin
            hp_d      = half_period;
            on_d      = on_periods;
            off_d     = off_periods;
            rep_d     = repeat_count;
            per_cnt_d = '0;
            beeps_d   = '0;
            buzzer_d  = 1'b1;
            state_d   = TONE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      TONE: begin
        if (stop) begin
          // A beep finishing on the same edge is not counted.
          state_d  = IDLE;
          buzzer_d = 1'b0;
          done_d   = 1'b1;
        end else if (period_tick) begin
          if (per_cnt_q == on_q - CNT_W'(1)) begin
            beeps_d   = beeps_inc;
            per_cnt_d = '0;
            if ((rep_q != '0) && (beeps_inc == rep_q)) begin
              state_d  = IDLE;
              buzzer_d = 1'b0;
              done_d   = 1'b1;
            end else if (off_q == '0) begin
              buzzer_d = 1'b1;
            end else begin
              state_d  = GAP;
              buzzer_d = 1'b0;
            end
          end else begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
            buzzer_d  = 1'b1;
          end
        end else if (half_tick) begin
          buzzer_d = ~buzzer_q;
        end
      end

      GAP: begin
        buzzer_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (period_tick) begin
          if (per_cnt_q == off_q - CNT_W'(1)) begin
            per_cnt_d = '0;
            buzzer_d  = 1'b1;
            state_d   = TONE;
          end else begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        buzzer_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      hp_q      <= '0;
      on_q      <= '0;
      off_q     <= '0;
      rep_q     <= '0;
      per_cnt_q <= '0;
      beeps_q   <= '0;
      buzzer_q  <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      on_q      <= on_d;
      off_q     <= off_d;
      rep_q     <= rep_d;
      per_cnt_q <= per_cnt_d;
      beeps_q   <= beeps_d;
      buzzer_q  <= buzzer_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign buzzer_o   = buzzer_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign beeps_done = beeps_q;

endmodule : buzzer_tone_gen

// File: tb/tb_buzzer_tone_gen.sv
// Randomized self-checking bench for buzzer_tone_gen. Expected waveforms are
// computed arithmetically from the sequence timing (beep length, gap length,
// repeat count) relative to the accepting start edge.
module tb_buzzer_tone_gen;

  localparam int HP_W  = 24;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic             ACLK;
  logic             ARESETN;
  logic             start;
  logic             stop;
  logic [HP_W-1:0]  half_period;
  logic [CNT_W-1:0] on_periods;
  logic [CNT_W-1:0] off_periods;
  logic [REP_W-1:0] repeat_count;
  logic             buzzer_o;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [REP_W-1:0] beeps_done;

  int err_cnt  = 0;
  int chk_cnt  = 0;
  int last_beeps = 0;

  buzzer_tone_gen #(
    .HP_W (HP_W),
    .CNT_W(CNT_W),
    .REP_W(REP_W)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .on_periods  (on_periods),
    .off_periods (off_periods),
    .repeat_count(repeat_count),
    .buzzer_o    (buzzer_o),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .beeps_done  (beeps_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Sample one cycle after the active edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int exp_done, input int exp_err);
    chk({tag, ".buzzer"}, 32'(buzzer_o), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(exp_err));
    chk({tag, ".beeps"}, 32'(beeps_done), 32'(last_beeps));
  endtask

  // Beeps fully completed by cycle k (k = 0 is the first cycle after start).
  function automatic int completed(input int k, input int len, input int unit, input int rep);
    int c;
    c = (k < len) ? 0 : (k - len) / unit + 1;
    if (rep != 0 && c > rep) c = rep;
    if (c > 255) c = 255;
    return c;
  endfunction

  // Run one sequence. stop_k > 0: stop takes effect in cycle stop_k.
  // junk_k > 0: an extra start arrives in cycle junk_k while busy.
  // Inputs are scrambled every cycle after the start edge.
  task automatic run_seq(input int hp, input int on, input int off, input int rep,
                         input int stop_k, input int junk_k, input string tag);
    int len, gap, unit, k_end, last, r;
    int e_busy, e_buz, e_done, e_beeps;
    len   = on * 2 * hp;
    gap   = off * 2 * hp;
    unit  = len + gap;
    k_end = (rep != 0) ? rep * unit - gap : 32'h7fff_ffff;
    last  = (stop_k > 0) ? stop_k : k_end;
    half_period  = HP_W'(hp);
    on_periods   = CNT_W'(on);
    off_periods  = CNT_W'(off);
    repeat_count = REP_W'(rep);
    start = 1'b1;
    stop  = 1'b0;
    for (int k = 0; k <= last + 3; k++) begin
      tick();
      if (stop_k > 0 && k >= stop_k) begin
        e_busy = 0; e_buz = 0; e_done = (k == stop_k);
        e_beeps = completed(stop_k - 1, len, unit, rep);
      end else if (k >= k_end) begin
        e_busy = 0; e_buz = 0; e_done = (k == k_end);
        e_beeps = rep;
      end else begin
        r = k % unit;
        e_busy = 1; e_done = 0;
        e_buz = (r < len && ((r / hp) % 2) == 0) ? 1 : 0;
        e_beeps = completed(k, len, unit, rep);
      end
      chk({tag, ".buzzer"}, 32'(buzzer_o), 32'(e_buz));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".cfg_err"}, 32'(cfg_err), 0);
      chk({tag, ".beeps"}, 32'(beeps_done), 32'(e_beeps));
      last_beeps = e_beeps;
      half_period  = HP_W'($urandom_range(0, 7));
      on_periods   = CNT_W'($urandom_range(0, 3));
      off_periods  = CNT_W'($urandom_range(0, 3));
      repeat_count = REP_W'($urandom_range(0, 3));
      start = (k + 1 == junk_k);
      stop  = (k + 1 == stop_k) || (k >= last && ($urandom % 2 == 1));
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // A rejected start: cfg_err for one cycle, nothing else moves.
  task automatic bad_start(input int hp, input int on, input string tag);
    half_period = HP_W'(hp);
    on_periods  = CNT_W'(on);
    off_periods = CNT_W'(1);
    repeat_count = REP_W'(1);
    start = 1'b1;
    stop  = 1'b0;
    tick();
    start = 1'b0;
    chk_idle({tag, ".pulse"}, 0, 1);
    tick();
    chk_idle({tag, ".after"}, 0, 0);
  endtask

  task automatic start_stop_idle(input string tag);
    half_period = HP_W'(3);
    on_periods  = CNT_W'(2);
    off_periods = CNT_W'(1);
    repeat_count = REP_W'(1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_idle({tag, ".c1"}, 0, 0);
    tick();
    chk_idle({tag, ".c2"}, 0, 0);
  endtask

  initial begin
    int hp, on, off, rep, len, gap, unit, k_end, stop_k, junk_k, last;
    ARESETN = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    half_period  = '0;
    on_periods   = '0;
    off_periods  = '0;
    repeat_count = '0;
    #1;
    chk_idle("reset.async", 0, 0);
    repeat (2) @(posedge ACLK);
    #2 ARESETN = 1'b1;
    tick();
    chk_idle("reset.idle", 0, 0);

    // Directed scenarios from the sequence description.
    run_seq(3, 2, 1, 2, 0, 0, "plan1");
    chk("plan1.final_beeps", 32'(beeps_done), 2);
    run_seq(2, 1, 0, 3, 0, 0, "plan2");
    chk("plan2.final_beeps", 32'(beeps_done), 3);
    run_seq(2, 1, 1, 0, 19, 0, "plan3");
    chk("plan3.final_beeps", 32'(beeps_done), 2);
    bad_start(1, 2, "bad_hp");
    bad_start(0, 1, "bad_hp0");
    bad_start(3, 0, "bad_on");
    run_seq(3, 2, 1, 2, 0, 10, "restart_ignored");
    start_stop_idle("start_stop");
    run_seq(2, 1, 0, 0, 1100, 500, "saturate");
    chk("saturate.final_beeps", 32'(beeps_done), 255);

    // Asynchronous reset between edges in the middle of a tone.
    half_period = HP_W'(3); on_periods = CNT_W'(2);
    off_periods = CNT_W'(1); repeat_count = REP_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("arst.pre_busy", 32'(busy), 1);
    chk("arst.pre_buzzer", 32'(buzzer_o), 1);
    #2 ARESETN = 1'b0;
    #1;
    last_beeps = 0;
    chk_idle("arst.now", 0, 0);
    tick();
    chk_idle("arst.held", 0, 0);
    #2 ARESETN = 1'b1;
    tick();
    chk_idle("arst.released", 0, 0);
    run_seq(3, 2, 1, 2, 0, 0, "arst.fresh");

    // Randomized sequences with optional stop, junk start, and rejected
    // or start+stop strobes between them.
    for (int n = 0; n < 30; n++) begin
      hp  = $urandom_range(2, 4);
      on  = $urandom_range(1, 3);
      off = $urandom_range(0, 2);
      rep = $urandom_range(0, 3);
      len = on * 2 * hp;
      gap = off * 2 * hp;
      unit = len + gap;
      k_end = rep * unit - gap;
      if (rep == 0) stop_k = $urandom_range(1, 60);
      else if ($urandom % 3 == 0) stop_k = $urandom_range(1, k_end);
      else stop_k = 0;
      last = (stop_k > 0) ? stop_k : k_end;
      junk_k = ($urandom % 2 == 1) ? $urandom_range(1, last) : 0;
      $display("run %0d: hp=%0d on=%0d off=%0d rep=%0d stop_k=%0d junk_k=%0d", n, hp, on, off, rep, stop_k, junk_k);
      run_seq(hp, on, off, rep, stop_k, junk_k, "rand");
      case ($urandom % 3)
        0: bad_start($urandom_range(0, 1), $urandom_range(1, 3), "rand_bad_hp");
        1: bad_start($urandom_range(2, 5), 0, "rand_bad_on");
        default: start_stop_idle("rand_start_stop");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_buzzer_tone_gen
